// File: rtl/aes_128_subbytes_if.sv
// -----------------------------------------------------------------------------
// aes_128_subbytes_if
// Bus between the SubBytes sequencer and the dual-port S-box BRAM.
//   clka, clkb             : S-box port clocks (driven from the sequencer clock)
//   sbox_addra, sbox_addrb : read addresses, port A = even byte, port B = odd byte
//   sbox_wea, sbox_web     : write enables (always 0, the table is read-only here)
//   sbox_dia, sbox_dib     : write data (always 0)
//   sbox_kill              : synchronous abort forwarded to the S-box
//   sbox_doa, sbox_dob     : read data returned by the S-box
// Modports: master = sequencer side, slave = S-box side.
// -----------------------------------------------------------------------------
interface aes_128_subbytes_if;
    logic       clka;
    logic       clkb;
    logic [7:0] sbox_addra;
    logic [7:0] sbox_addrb;
    logic       sbox_wea;
    logic       sbox_web;
    logic [7:0] sbox_dia;
    logic [7:0] sbox_dib;
    logic       sbox_kill;
    logic [7:0] sbox_doa;
    logic [7:0] sbox_dob;

    modport master (
        output clka, clkb, sbox_addra, sbox_addrb, sbox_wea, sbox_web,
               sbox_dia, sbox_dib, sbox_kill,
        input  sbox_doa, sbox_dob
    );

    modport slave (
        input  clka, clkb, sbox_addra, sbox_addrb, sbox_wea, sbox_web,
               sbox_dia, sbox_dib, sbox_kill,
        output sbox_doa, sbox_dob
    );
endinterface

// File: rtl/aes_128_subbytes.sv
// -----------------------------------------------------------------------------
// aes_128_subbytes
// Sequencer for the AES-128 SubBytes step. A 128-bit state is streamed through
// a dual-port S-box BRAM two bytes per cycle (port A = even byte, port B = odd
// byte) and the substituted bytes are reassembled into data_out.
//
// Optional macro AES_SUBBYTES_SHIFTROWS_EN: when defined, ShiftRows is folded
// into the data_out load as pure wiring (no latency change).
//
// Parameters:
//   SBOX_LATENCY : S-box read latency, 1 or 2 cycles (2 = output-registered BRAM)
// Ports:
//   clk       : clock, also forwarded to S-box clka/clkb
//   rst_n     : asynchronous active-low reset
//   kill      : synchronous abort, active high, priority over start
//   start     : request to process data_in, honoured only when busy = 0
//   data_in   : input state, byte i = data_in[127-8i -: 8]
//   busy      : operation in progress
//   done      : one-cycle pulse, data_out valid from this cycle on
//   data_out  : result, held until the next done or kill
//   sbox      : S-box bus (master side)
// -----------------------------------------------------------------------------
module aes_128_subbytes #(
    parameter int SBOX_LATENCY = 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      kill,
    input  logic                      start,
    input  logic [127:0]              data_in,
    output logic                      busy,
    output logic                      done,
    output logic [127:0]              data_out,
    aes_128_subbytes_if.master        sbox
);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} fsm_t;

    fsm_t                          fsm_reg;
    logic [127:0]                  state_reg;
    logic [127:0]                  result_reg;
    logic [2:0]                    cnt_reg;
    logic [7:0]                    addra_reg;
    logic [7:0]                    addrb_reg;
    // Tag of the pair whose address is currently on the S-box bus.
    logic                          issue_vld_reg;
    logic [2:0]                    issue_idx_reg;
    // Tags follow the pair through the S-box read latency.
    logic [SBOX_LATENCY-1:0]       pipe_vld_reg;
    logic [SBOX_LATENCY-1:0][2:0]  pipe_idx_reg;

    logic                          cap_vld;
    logic [2:0]                    cap_idx;
    logic [127:0]                  merged;
    logic [127:0]                  final_res;
    logic [7:0]                    state_bytes [16];

    assign cap_vld = pipe_vld_reg[SBOX_LATENCY-1];
    assign cap_idx = pipe_idx_reg[SBOX_LATENCY-1];

    assign sbox.clka       = clk;
    assign sbox.clkb       = clk;
    assign sbox.sbox_addra = addra_reg;
    assign sbox.sbox_addrb = addrb_reg;
    assign sbox.sbox_wea   = 1'b0;
    assign sbox.sbox_web   = 1'b0;
    assign sbox.sbox_dia   = 8'h00;
    assign sbox.sbox_dib   = 8'h00;
    assign sbox.sbox_kill  = kill;

    genvar gi;
    generate
        for (gi = 0; gi < 16; gi++) begin : g_bytes
            assign state_bytes[gi] = state_reg[127-8*gi -: 8];
        end

        // Result with the pair arriving this cycle already merged in, so the
        // final pair can be loaded into data_out on the same edge it lands.
        for (gi = 0; gi < 8; gi++) begin : g_merge
            assign merged[127-16*gi -: 16] = (cap_vld && cap_idx == 3'(gi)) ?
                {sbox.sbox_doa, sbox.sbox_dob} : result_reg[127-16*gi -: 16];
        end

`ifdef AES_SUBBYTES_SHIFTROWS_EN
        // Output byte r+4c comes from substituted byte r+4((c+r) mod 4).
        for (gi = 0; gi < 16; gi++) begin : g_shift_rows
            localparam int R   = gi % 4;
            localparam int C   = gi / 4;
            localparam int SRC = R + 4 * ((C + R) % 4);
            assign final_res[127-8*gi -: 8] = merged[127-8*SRC -: 8];
        end
`else
        assign final_res = merged;
`endif
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_reg       <= IDLE;
            state_reg     <= '0;
            result_reg    <= '0;
            cnt_reg       <= '0;
            addra_reg     <= '0;
            addrb_reg     <= '0;
            issue_vld_reg <= 1'b0;
            issue_idx_reg <= '0;
            pipe_vld_reg  <= '0;
            pipe_idx_reg  <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            data_out      <= '0;
        end else if (kill) begin
            // Addresses deliberately keep their last value.
            fsm_reg       <= IDLE;
            cnt_reg       <= '0;
            issue_vld_reg <= 1'b0;
            pipe_vld_reg  <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            data_out      <= '0;
        end else begin
            done          <= 1'b0;
            issue_vld_reg <= 1'b0;
            result_reg    <= merged;
            pipe_vld_reg[0] <= issue_vld_reg;
            pipe_idx_reg[0] <= issue_idx_reg;
            for (int i = 1; i < SBOX_LATENCY; i++) begin
                pipe_vld_reg[i] <= pipe_vld_reg[i-1];
                pipe_idx_reg[i] <= pipe_idx_reg[i-1];
            end

            case (fsm_reg)
                IDLE: begin
                    if (start) begin
                        // Pair 0 goes straight from data_in; the rest come
                        // from the latched copy.
                        state_reg     <= data_in;
                        addra_reg     <= data_in[127:120];
                        addrb_reg     <= data_in[119:112];
                        issue_vld_reg <= 1'b1;
                        issue_idx_reg <= 3'd0;
                        cnt_reg       <= 3'd1;
                        busy          <= 1'b1;
                        fsm_reg       <= ISSUE;
                    end
                end
                ISSUE: begin
                    addra_reg     <= state_bytes[{cnt_reg, 1'b0}];
                    addrb_reg     <= state_bytes[{cnt_reg, 1'b1}];
                    issue_vld_reg <= 1'b1;
                    issue_idx_reg <= cnt_reg;
                    cnt_reg       <= cnt_reg + 3'd1;
                    if (cnt_reg == 3'd7) begin
                        fsm_reg <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (cap_vld && cap_idx == 3'd7) begin
                        data_out <= final_res;
                        done     <= 1'b1;
                        busy     <= 1'b0;
                        fsm_reg  <= IDLE;
                    end
                end
                default: fsm_reg <= IDLE;
            endcase
        end
    end

endmodule
